// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared state encoding, access-mode flags and port-select constants for dmem_arbiter
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    localparam logic [3:0] MODE_W = 4'b1000;
    localparam logic [3:0] MODE_H = 4'b0100;
    localparam logic [3:0] MODE_B = 4'b0010;
    localparam logic [3:0] MODE_Z = 4'b0001;

    localparam logic SEL_CPU = 1'b0;
    localparam logic SEL_DMA = 1'b1;

endpackage

// File: rtl/dmem_arb_pick.sv
// rtl/dmem_arb_pick.sv - winner selection (fixed priority with starvation guard, or round-robin under DMEM_ARB_RR_EN)
module dmem_arb_pick
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic c_req,
    input  logic d_req,
    input  logic grant,
    output logic win
);

`ifdef DMEM_ARB_RR_EN

    logic rr_last;

    // On a tie the port that did not win last time goes; a lone request always wins.
    always_comb begin
        win = SEL_CPU;
        if (c_req && d_req) begin
            win = ~rr_last;
        end else if (d_req) begin
            win = SEL_DMA;
        end
    end

    // Remember the most recent grant; starts as DMA so the CPU wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last <= SEL_DMA;
        end else if (grant) begin
            rr_last <= win;
        end
    end

`else

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_cnt;

    // CPU wins ties until DMA has lost LIMIT arbitrations in a row.
    always_comb begin
        win = SEL_CPU;
        if (d_req && (!c_req || starve_cnt == LIMIT)) begin
            win = SEL_DMA;
        end
    end

    // Count DMA losses (saturating) and clear once DMA is granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (grant) begin
            if (win == SEL_DMA) begin
                starve_cnt <= '0;
            end else if (d_req && starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

`endif

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/DMA data-memory arbiter and sequencer; DMEM_ARB_RR_EN selects round-robin arbitration
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [3:0]    c_mode,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_ack,
    output logic [DW-1:0] c_rdata,
    output logic          c_err,
    output logic          c_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [3:0]    d_mode,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          d_err,
    output logic          m_ena,
    output logic          m_wena,
    output logic [3:0]    m_mode,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_err
);

    state_t        state, state_nxt;
    logic          grant, win;
    logic          lat_sel, lat_we, err_lat;
    logic [3:0]    lat_mode;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic [DW-1:0] c_rdata_q, d_rdata_q;
    logic          c_err_q, d_err_q;

    assign grant   = (state == S_IDLE) && (c_req || d_req);
    assign c_stall = c_req & ~c_ack;

    dmem_arb_pick #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_pick (
        .clk   (clk),
        .rst   (rst),
        .c_req (c_req),
        .d_req (d_req),
        .grant (grant),
        .win   (win)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: one access per grant, always IDLE -> ISSUE -> RESP -> IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (grant) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Capture the winner's request on grant and the memory error while issuing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_sel   <= SEL_CPU;
            lat_we    <= 1'b0;
            lat_mode  <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            err_lat   <= 1'b0;
        end else begin
            if (grant) begin
                lat_sel   <= win;
                lat_we    <= (win == SEL_DMA) ? d_we    : c_we;
                lat_mode  <= (win == SEL_DMA) ? d_mode  : c_mode;
                lat_addr  <= (win == SEL_DMA) ? d_addr  : c_addr;
                lat_wdata <= (win == SEL_DMA) ? d_wdata : c_wdata;
            end
            if (state == S_ISSUE) begin
                err_lat <= m_err;
            end
        end
    end

    // Hold each port's last read data and error once its response cycle ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_rdata_q <= '0;
            c_err_q   <= 1'b0;
            d_rdata_q <= '0;
            d_err_q   <= 1'b0;
        end else if (state == S_RESP) begin
            if (lat_sel == SEL_CPU) begin
                c_rdata_q <= m_rdata;
                c_err_q   <= err_lat;
            end else begin
                d_rdata_q <= m_rdata;
                d_err_q   <= err_lat;
            end
        end
    end

    // Outputs: memory strobes only in ISSUE; ack and fresh data to the selected port in RESP.
    always_comb begin
        m_ena   = 1'b0;
        m_wena  = 1'b0;
        m_wdata = '0;
        m_addr  = lat_addr;
        m_mode  = lat_mode;
        c_ack   = 1'b0;
        d_ack   = 1'b0;
        c_rdata = c_rdata_q;
        c_err   = c_err_q;
        d_rdata = d_rdata_q;
        d_err   = d_err_q;
        case (state)
            S_ISSUE: begin
                m_ena   = 1'b1;
                m_wena  = lat_we;
                m_wdata = lat_wdata;
            end
            S_RESP: begin
                if (lat_sel == SEL_CPU) begin
                    c_ack   = 1'b1;
                    c_rdata = m_rdata;
                    c_err   = err_lat;
                end else begin
                    d_ack   = 1'b1;
                    d_rdata = m_rdata;
                    d_err   = err_lat;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed scoreboard testbench for dmem_arbiter
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        chk;
    } exp_t;

`ifdef DMEM_ARB_RR_EN
    localparam int N_C = 2;
    localparam int N_D = 2;
`else
    localparam int N_C = 4;
    localparam int N_D = 1;
`endif
    localparam int N_G = N_C + N_D;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        c_req = 1'b0, c_we = 1'b0;
    logic [3:0]  c_mode = '0;
    logic [31:0] c_addr = '0, c_wdata = '0;
    logic        c_ack, c_err, c_stall;
    logic [31:0] c_rdata;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [3:0]  d_mode = '0;
    logic [31:0] d_addr = '0, d_wdata = '0;
    logic        d_ack, d_err;
    logic [31:0] d_rdata;
    logic        m_ena, m_wena, m_err;
    logic [3:0]  m_mode;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] m_rdata = '0;

    int   checks = 0;
    int   errors = 0;
    exp_t cq[$];
    exp_t dq[$];
    exp_t ec, ed;
    logic [31:0] gq[$];
    int   lat;
    int   n_d;

    dmem_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_mode(c_mode), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ack(c_ack), .c_rdata(c_rdata), .c_err(c_err), .c_stall(c_stall),
        .d_req(d_req), .d_we(d_we), .d_mode(d_mode), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .m_ena(m_ena), .m_wena(m_wena), .m_mode(m_mode), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .m_err(m_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    function automatic logic addr_err(input logic [3:0] mode, input logic [31:0] a);
        return (mode == MODE_W && a[1:0] != 2'b00) || (mode == MODE_H && a[0]);
    endfunction

    function automatic logic [31:0] grant_exp(input int k);
`ifdef DMEM_ARB_RR_EN
        return (k % 2 == 0) ? 32'h20 : 32'h30;
`else
        return (k < N_C) ? 32'h20 : 32'h30;
`endif
    endfunction

    assign m_err = addr_err(m_mode, m_addr);

    always @(posedge clk) begin
        if (m_ena) m_rdata <= mem_f(m_addr);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && c_ack) begin
            if (cq.size() == 0) check("c_unexpected_ack", c_ack, 1'b0);
            else begin
                ec = cq.pop_front();
                if (ec.chk) check("c_rdata", c_rdata, ec.rdata);
                check("c_err", c_err, ec.err);
            end
        end
        if (!rst && d_ack) begin
            if (dq.size() == 0) check("d_unexpected_ack", d_ack, 1'b0);
            else begin
                ed = dq.pop_front();
                if (ed.chk) check("d_rdata", d_rdata, ed.rdata);
                check("d_err", d_err, ed.err);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        c_req = 1'b0;
        d_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic do_access(input logic port, input logic we, input logic [3:0] mode,
                             input logic [31:0] addr, input logic [31:0] wdata, output int l);
        @(posedge clk); #1;
        if (port == SEL_DMA) begin
            d_req = 1'b1; d_we = we; d_mode = mode; d_addr = addr; d_wdata = wdata;
            dq.push_back('{mem_f(addr), addr_err(mode, addr), ~we});
        end else begin
            c_req = 1'b1; c_we = we; c_mode = mode; c_addr = addr; c_wdata = wdata;
            cq.push_back('{mem_f(addr), addr_err(mode, addr), ~we});
        end
        l = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((port == SEL_DMA) ? d_ack : c_ack) begin
                l = i;
                break;
            end
        end
        @(posedge clk); #1;
        if (port == SEL_DMA) d_req = 1'b0;
        else c_req = 1'b0;
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        check("rst_c_ack", c_ack, 1'b0);
        check("rst_d_ack", d_ack, 1'b0);
        check("rst_c_rdata", c_rdata, 32'h0);
        check("rst_c_err", c_err, 1'b0);
        check("rst_m_ena", m_ena, 1'b0);
        check("rst_m_wena", m_wena, 1'b0);
        check("rst_m_addr", m_addr, 32'h0);
        check("rst_state", dut.state, S_IDLE);
        @(posedge clk); #1;
        rst = 1'b0;

        // CPU word read
        @(posedge clk); #1;
        c_req = 1'b1; c_we = 1'b0; c_mode = MODE_W; c_addr = 32'h10;
        cq.push_back('{32'hDEADBEEF, 1'b0, 1'b1});
        @(negedge clk);
        check("t1_stall_T", c_stall, 1'b1);
        check("t1_mena_T", m_ena, 1'b0);
        @(negedge clk);
        check("t1_mena_T1", m_ena, 1'b1);
        check("t1_maddr_T1", m_addr, 32'h10);
        check("t1_mmode_T1", m_mode, MODE_W);
        check("t1_mwena_T1", m_wena, 1'b0);
        check("t1_stall_T1", c_stall, 1'b1);
        check("t1_ack_T1", c_ack, 1'b0);
        @(negedge clk);
        check("t1_ack_T2", c_ack, 1'b1);
        check("t1_rdata_T2", c_rdata, 32'hDEADBEEF);
        check("t1_stall_T2", c_stall, 1'b0);
        check("t1_mena_T2", m_ena, 1'b0);
        check("t1_maddr_hold", m_addr, 32'h10);
        @(posedge clk); #1;
        c_req = 1'b0;
        @(negedge clk);
        check("t1_ack_pulse", c_ack, 1'b0);
        check("t1_rdata_held", c_rdata, 32'hDEADBEEF);

        // simultaneous requests
        do_reset();
        @(posedge clk); #1;
        c_req = 1'b1; c_we = 1'b1; c_mode = MODE_B; c_addr = 32'h04; c_wdata = 32'h55;
        d_req = 1'b1; d_we = 1'b0; d_mode = MODE_W; d_addr = 32'h08; d_wdata = 32'h0;
        cq.push_back('{mem_f(32'h04), 1'b0, 1'b0});
        dq.push_back('{mem_f(32'h08), 1'b0, 1'b1});
        @(negedge clk);
        check("t2_stall_T", c_stall, 1'b1);
        @(negedge clk);
        check("t2_mena_T1", m_ena, 1'b1);
        check("t2_mwena_T1", m_wena, 1'b1);
        check("t2_mmode_T1", m_mode, MODE_B);
        check("t2_maddr_T1", m_addr, 32'h04);
        check("t2_mwdata_T1", m_wdata, 32'h55);
        @(negedge clk);
        check("t2_cack_T2", c_ack, 1'b1);
        check("t2_dack_T2", d_ack, 1'b0);
        @(posedge clk); #1;
        c_req = 1'b0;
        @(negedge clk);
        check("t2_mena_T3", m_ena, 1'b0);
        check("t2_mwdata_T3", m_wdata, 32'h0);
        @(negedge clk);
        check("t2_mena_T4", m_ena, 1'b1);
        check("t2_maddr_T4", m_addr, 32'h08);
        check("t2_mwena_T4", m_wena, 1'b0);
        @(negedge clk);
        check("t2_dack_T5", d_ack, 1'b1);
        check("t2_cack_T5", c_ack, 1'b0);
        @(posedge clk); #1;
        d_req = 1'b0;

        // continuous contention: starvation guard or round-robin alternation
        @(posedge clk); #1;
        c_req = 1'b1; c_we = 1'b0; c_mode = MODE_W; c_addr = 32'h20;
        d_req = 1'b1; d_we = 1'b0; d_mode = MODE_W; d_addr = 32'h30;
        for (int k = 0; k < N_C; k++) cq.push_back('{mem_f(32'h20), 1'b0, 1'b1});
        for (int k = 0; k < N_D; k++) dq.push_back('{mem_f(32'h30), 1'b0, 1'b1});
        n_d = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (m_ena) gq.push_back(m_addr);
            if (d_ack) n_d++;
            if (n_d == N_D) break;
        end
        @(posedge clk); #1;
        c_req = 1'b0;
        d_req = 1'b0;
        check("t3_grant_count", gq.size(), N_G);
        for (int k = 0; k < N_G && k < gq.size(); k++) begin
            check($sformatf("t3_grant%0d", k), gq[k], grant_exp(k));
        end
`ifndef DMEM_ARB_RR_EN
        check("t3_starve_clear", dut.u_pick.starve_cnt, 0);
`endif

        // address error, then a clean access and a DMA write
        do_access(SEL_CPU, 1'b0, MODE_H, 32'h03, 32'h0, lat);
        check("t4_err_lat", lat, 2);
        @(negedge clk);
        check("t4_err_held", c_err, 1'b1);
        do_access(SEL_CPU, 1'b0, MODE_W, 32'h40, 32'h0, lat);
        check("t4_clean_lat", lat, 2);
        @(negedge clk);
        check("t4_err_clear", c_err, 1'b0);
        do_access(SEL_DMA, 1'b1, MODE_W, 32'h44, 32'h1234, lat);
        check("t4_dma_lat", lat, 2);

        // reset during RESP abandons the access
        @(posedge clk); #1;
        c_req = 1'b1; c_we = 1'b0; c_mode = MODE_W; c_addr = 32'h50;
        @(negedge clk);
        @(negedge clk);
        check("t5_mena_T1", m_ena, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        c_req = 1'b0;
        @(negedge clk);
        check("t5_no_ack", c_ack, 1'b0);
        check("t5_mena", m_ena, 1'b0);
        check("t5_state", dut.state, S_IDLE);
        check("t5_rdata_rst", c_rdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        do_access(SEL_CPU, 1'b0, MODE_W, 32'h60, 32'h0, lat);
        check("t5_fresh_lat", lat, 2);

        @(negedge clk);
        check("sb_cpu_empty", cq.size(), 0);
        check("sb_dma_empty", dq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
